button_mode_select: RTL and testbench

Parametrised successor to the top-level difficulty button logic. Conditions NUM_BTN raw board buttons with a synchroniser, per-channel debounce and rising-edge detection. Latches a MODE_W-bit mode value selected by priority. Sits between the board button pins and the processor's difficulty input, and adds lock, default-mode and change-notification behaviour.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/button_mode_select_if.sv | 44 ++++
 rtl/btn_debounce.sv | 71 +++++++
 rtl/button_mode_select.sv | 82 ++++++++
 tb/tb_button_mode_select.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants for the difficulty button front-end.
//   DEFAULT_DEBOUNCE_50MHZ : 10 ms debounce window at 50 MHz
//   MODE_W_DEFAULT         : default width of the mode register
//   MODE_EASY/MED/HARD     : named mode values (channel i selects i+1)
//   mode_for_channel()     : maps a button channel index to its mode value
// -----------------------------------------------------------------------------
package btn_pkg;

    localparam int DEFAULT_DEBOUNCE_50MHZ = 500000;
    localparam int MODE_W_DEFAULT         = 32;

    localparam int unsigned MODE_EASY = 1;
    localparam int unsigned MODE_MED  = 2;
    localparam int unsigned MODE_HARD = 3;

    function automatic int unsigned mode_for_channel(input int unsigned idx);
        return idx + 1;
    endfunction

endpackage

// File: rtl/button_mode_select_if.sv
// -----------------------------------------------------------------------------
// button_mode_select_if
// Groups the button inputs and the mode-select outputs.
//   btn_raw      : raw asynchronous button levels (active-high)
//   lock         : blocks mode changes while high
//   btn_level    : debounced levels
//   btn_press    : one-cycle pulse per debounced rising edge
//   mode         : selected mode value
//   mode_changed : one-cycle pulse when mode takes a new value
// master drives the buttons/lock, slave is the mode-select block.
// -----------------------------------------------------------------------------
interface button_mode_select_if
    import btn_pkg::*;
#(
    parameter int NUM_BTN = 5,
    parameter int MODE_W  = MODE_W_DEFAULT
);

    logic [NUM_BTN-1:0] btn_raw;
    logic               lock;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_press;
    logic [MODE_W-1:0]  mode;
    logic               mode_changed;

    modport master (
        output btn_raw,
        output lock,
        input  btn_level,
        input  btn_press,
        input  mode,
        input  mode_changed
    );

    modport slave (
        input  btn_raw,
        input  lock,
        output btn_level,
        output btn_press,
        output mode,
        output mode_changed
    );

endinterface

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button channel: 2-flop synchroniser, stability counter, debounced level
// and a registered rising-edge pulse.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   raw_i   : raw asynchronous button level
//   level_o : debounced level (changes after DEBOUNCE_CYCLES stable cycles)
//   press_o : high for one cycle, the cycle after level_o rises
// -----------------------------------------------------------------------------
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic level_o,
    output logic press_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q;
    logic             press_q, press_d;

    // Count consecutive disagreements between the synchronised input and the
    // accepted level; any agreement restarts the window. The terminal compare
    // keeps the counter from ever wrapping.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Pulse is taken from the registered level so it lands one cycle
        // after the level rises.
        press_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
        end else begin
            sync1_q     <= raw_i;
            sync2_q     <= sync1_q;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= press_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/button_mode_select.sv
// -----------------------------------------------------------------------------
// button_mode_select
// Conditions NUM_BTN raw buttons (sync + debounce + press detect) and latches
// a mode value chosen by the lowest-index press, with lock and change pulse.
//   clock      : system clock (50 MHz domain)
//   anti_reset : asynchronous active-low reset
//   bus        : button_mode_select_if slave (btn_raw, lock in;
//                btn_level, btn_press, mode, mode_changed out)
// -----------------------------------------------------------------------------
module button_mode_select
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_50MHZ,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int MODE_W          = MODE_W_DEFAULT,
    parameter int DEFAULT_MODE    = int'(MODE_EASY)
) (
    input  logic                 clock,
    input  logic                 anti_reset,
    button_mode_select_if.slave  bus
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] press;

    logic [MODE_W-1:0]  mode_q, mode_d;
    logic               mode_changed_q, mode_changed_d;
    logic               hit;
    logic [MODE_W-1:0]  sel_mode;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk_i   (clock),
            .rst_ni  (anti_reset),
            .raw_i   (bus.btn_raw[g]),
            .level_o (level[g]),
            .press_o (press[g])
        );
    end

    // Lowest set press index wins.
    always_comb begin
        hit      = 1'b0;
        sel_mode = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (press[i] && !hit) begin
                hit      = 1'b1;
                sel_mode = MODE_W'(mode_for_channel(i));
            end
        end
    end

    // Presses under lock are simply dropped; nothing is remembered for later.
    always_comb begin
        mode_d         = mode_q;
        mode_changed_d = 1'b0;
        if (!bus.lock && hit) begin
            mode_d         = sel_mode;
            mode_changed_d = (sel_mode != mode_q);
        end
    end

    always_ff @(posedge clock or negedge anti_reset) begin
        if (!anti_reset) begin
            mode_q         <= MODE_W'(DEFAULT_MODE);
            mode_changed_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    assign bus.btn_level    = level;
    assign bus.btn_press    = press;
    assign bus.mode         = mode_q;
    assign bus.mode_changed = mode_changed_q;

endmodule

// File: tb/tb_button_mode_select.sv
// -----------------------------------------------------------------------------
// tb_button_mode_select
// Two instances: A with a 4-cycle debounce window, B with a 1-cycle window.
// The bench keeps a history-based model of each instance and compares all
// outputs on every falling clock edge outside reset, plus literal checks at
// hand-computed cycles.
// -----------------------------------------------------------------------------
module tb_button_mode_select;
    import btn_pkg::*;

    localparam int NB = 5;
    localparam int MW = 32;
    localparam int HD = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_mode_select_if #(.NUM_BTN(NB), .MODE_W(MW)) bus_a ();
    button_mode_select_if #(.NUM_BTN(NB), .MODE_W(MW)) bus_b ();

    button_mode_select #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .MODE_W(MW), .DEFAULT_MODE(1)
    ) dut_a (
        .clock(clk), .anti_reset(rst_n), .bus(bus_a)
    );

    button_mode_select #(
        .NUM_BTN(NB), .DEBOUNCE_CYCLES(1), .MODE_W(MW), .DEFAULT_MODE(1)
    ) dut_b (
        .clock(clk), .anti_reset(rst_n), .bus(bus_b)
    );

    int errors = 0;
    int checks = 0;
    int pcount_b = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // rawh[x][j]: raw vector sampled j+1 edges ago (index 0 = latest sample).
    // The synchronised value seen at an edge is the raw sample two edges back,
    // so a level flips once the last DC such values all disagree with it.
    int              dcv [2] = '{4, 1};
    logic [NB-1:0]   rawh [2][HD];
    logic [NB-1:0]   ml [2];
    logic [NB-1:0]   mp [2];
    logic [NB-1:0]   mr [2];
    logic [MW-1:0]   mm [2];
    logic            mc [2];

    task automatic model_reset();
        for (int x = 0; x < 2; x++) begin
            for (int j = 0; j < HD; j++) rawh[x][j] = '0;
            ml[x] = '0;
            mp[x] = '0;
            mr[x] = '0;
            mm[x] = MW'(MODE_EASY);
            mc[x] = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                for (int x = 0; x < 2; x++) begin
                    logic [NB-1:0] nl, oldp, rawin;
                    logic          lk;
                    int            k;
                    rawin = (x == 0) ? bus_a.btn_raw : bus_b.btn_raw;
                    lk    = (x == 0) ? bus_a.lock    : bus_b.lock;
                    oldp  = mp[x];
                    nl    = ml[x];
                    for (int ch = 0; ch < NB; ch++) begin
                        logic all_diff;
                        all_diff = 1'b1;
                        for (int j = 0; j < dcv[x]; j++)
                            if (rawh[x][1+j][ch] == ml[x][ch]) all_diff = 1'b0;
                        if (all_diff) nl[ch] = ~ml[x][ch];
                    end
                    mp[x] = mr[x];
                    mr[x] = nl & ~ml[x];
                    ml[x] = nl;
                    mc[x] = 1'b0;
                    if (!lk && oldp != '0) begin
                        k = 0;
                        for (int ch = NB - 1; ch >= 0; ch--) if (oldp[ch]) k = ch;
                        if (MW'(k + 1) != mm[x]) mc[x] = 1'b1;
                        mm[x] = MW'(k + 1);
                    end
                    for (int j = HD - 1; j > 0; j--) rawh[x][j] = rawh[x][j-1];
                    rawh[x][0] = rawin;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("a_level",   64'(bus_a.btn_level),    64'(ml[0]));
                chk("a_press",   64'(bus_a.btn_press),    64'(mp[0]));
                chk("a_mode",    64'(bus_a.mode),         64'(mm[0]));
                chk("a_changed", 64'(bus_a.mode_changed), 64'(mc[0]));
                chk("b_level",   64'(bus_b.btn_level),    64'(ml[1]));
                chk("b_press",   64'(bus_b.btn_press),    64'(mp[1]));
                chk("b_mode",    64'(bus_b.mode),         64'(mm[1]));
                chk("b_changed", 64'(bus_b.mode_changed), 64'(mc[1]));
                if (bus_b.btn_press[0]) pcount_b++;
            end
        end
    end

    // Advance n rising edges, then step 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus_a.btn_raw = '0; bus_a.lock = 1'b0;
        bus_b.btn_raw = '0; bus_b.lock = 1'b0;
        rst_n = 1'b0;
        cyc(3);
        chk("rst_a_mode",  64'(bus_a.mode), 64'(1));
        chk("rst_a_level", 64'(bus_a.btn_level), 64'(0));
        rst_n = 1'b1;
        cyc(5);

        // clean press on channel 1
        bus_a.btn_raw = 5'b00010;
        cyc(5);
        chk("press_lvl_early", 64'(bus_a.btn_level), 64'(0));
        cyc(1);
        chk("press_lvl_6",     64'(bus_a.btn_level), 64'(5'b00010));
        chk("press_pulse_pre", 64'(bus_a.btn_press), 64'(0));
        cyc(1);
        chk("press_pulse",     64'(bus_a.btn_press), 64'(5'b00010));
        chk("press_mode_old",  64'(bus_a.mode),      64'(1));
        cyc(1);
        chk("press_mode_new",  64'(bus_a.mode),      64'(MODE_MED));
        chk("press_changed",   64'(bus_a.mode_changed), 64'(1));
        chk("press_pulse_end", 64'(bus_a.btn_press), 64'(0));
        cyc(1);
        chk("press_changed_end", 64'(bus_a.mode_changed), 64'(0));
        cyc(100);
        chk("hold_mode",  64'(bus_a.mode), 64'(MODE_MED));
        chk("hold_press", 64'(bus_a.btn_press), 64'(0));
        bus_a.btn_raw = '0;
        cyc(10);

        // glitch of 3 cycles on channel 2 is rejected
        bus_a.btn_raw = 5'b00100;
        cyc(3);
        bus_a.btn_raw = '0;
        cyc(12);
        chk("glitch_level", 64'(bus_a.btn_level), 64'(0));
        chk("glitch_mode",  64'(bus_a.mode), 64'(MODE_MED));
        bus_a.btn_raw = 5'b00100;
        cyc(10);
        chk("stable_mode", 64'(bus_a.mode), 64'(MODE_HARD));
        bus_a.btn_raw = '0;
        cyc(10);

        // simultaneous channels 3 and 0
        bus_a.btn_raw = 5'b01001;
        cyc(7);
        chk("simul_press", 64'(bus_a.btn_press), 64'(5'b01001));
        cyc(1);
        chk("simul_mode",    64'(bus_a.mode), 64'(MODE_EASY));
        chk("simul_changed", 64'(bus_a.mode_changed), 64'(1));
        bus_a.btn_raw = '0;
        cyc(10);
        bus_a.btn_raw = 5'b01001;
        cyc(8);
        chk("simul2_mode",    64'(bus_a.mode), 64'(MODE_EASY));
        chk("simul2_changed", 64'(bus_a.mode_changed), 64'(0));
        bus_a.btn_raw = '0;
        cyc(10);

        // lock drops presses
        bus_a.lock = 1'b1;
        bus_a.btn_raw = 5'b00100;
        cyc(7);
        chk("lock_press", 64'(bus_a.btn_press), 64'(5'b00100));
        cyc(1);
        chk("lock_mode",    64'(bus_a.mode), 64'(MODE_EASY));
        chk("lock_changed", 64'(bus_a.mode_changed), 64'(0));
        bus_a.btn_raw = '0;
        cyc(10);
        bus_a.lock = 1'b0;
        cyc(10);
        chk("unlock_mode", 64'(bus_a.mode), 64'(MODE_EASY));
        bus_a.btn_raw = 5'b00100;
        cyc(8);
        chk("unlock_press_mode", 64'(bus_a.mode), 64'(MODE_HARD));
        cyc(5);
        chk("held_level", 64'(bus_a.btn_level), 64'(5'b00100));

        // asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mode",    64'(bus_a.mode), 64'(1));
        chk("async_rst_level",   64'(bus_a.btn_level), 64'(0));
        chk("async_rst_press",   64'(bus_a.btn_press), 64'(0));
        chk("async_rst_changed", 64'(bus_a.mode_changed), 64'(0));
        cyc(2);
        rst_n = 1'b1;
        bus_a.btn_raw = '0;
        cyc(10);

        // 1-cycle debounce instance
        bus_b.btn_raw = 5'b00001;
        cyc(2);
        chk("b_lat_early", 64'(bus_b.btn_level), 64'(0));
        cyc(1);
        chk("b_lat_3", 64'(bus_b.btn_level), 64'(5'b00001));
        cyc(1);
        chk("b_press_1", 64'(bus_b.btn_press), 64'(5'b00001));
        bus_b.btn_raw = '0;
        cyc(10);
        pcount_b = 0;
        for (int i = 0; i < 10; i++) begin
            bus_b.btn_raw = 5'b00001;
            cyc(2);
            bus_b.btn_raw = '0;
            cyc(2);
        end
        cyc(10);
        chk("b_press_count", 64'(pcount_b), 64'(10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
